// File: rtl/blkmem_wb.sv
// Purpose: registered-output block RAM bus slave with byte strobes and out-of-range error.
// Latency: ack/err is registered WAIT_STATES+1 edges after acceptance; WAIT_STATES+2 cycles per access.
// Backpressure: requests are only taken in IDLE; the master holds i_cyc/i_stb until it sees ack or err.
module blkmem_wb #(
  parameter int DW          = 16,
  parameter int AW          = 15,
  parameter int DEPTH       = 2**AW,
  parameter int WAIT_STATES = 0
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [DW-1:0]   i_dat,
  output logic [DW-1:0]   o_dat,
  input  logic [AW-1:0]   i_addr,
  input  logic            i_we,
  input  logic            i_cyc,
  input  logic [DW/8-1:0] i_stb,
  output logic            o_ack,
  output logic            o_err,
  output logic            o_busy
);

  localparam int SW = DW / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [3:0]  WS4     = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [SW-1:0] stb_q;
  logic [DW-1:0] dat_q;
  logic [SW-1:0] rd_mask_q;
  logic [DW-1:0] rd_q;

  logic [DW-1:0] mem [DEPTH];

  logic          req;
  logic          go_resp;
  logic [AW-1:0] acc_addr;
  logic          acc_we;
  logic [SW-1:0] acc_stb;
  logic [DW-1:0] acc_dat;
  logic          in_range;
  logic [IW-1:0] mem_idx;
  logic          mem_wr;
  logic          mem_rd;
  logic [SW-1:0] resp_mask;

  assign req = i_cyc & (|i_stb);

  // With no wait states the access completes on the accepting edge, so the
  // live bus fields are used in IDLE; otherwise the latched copies are used.
  assign acc_addr = (state_q == S_IDLE) ? i_addr : addr_q;
  assign acc_we   = (state_q == S_IDLE) ? i_we   : we_q;
  assign acc_stb  = (state_q == S_IDLE) ? i_stb  : stb_q;
  assign acc_dat  = (state_q == S_IDLE) ? i_dat  : dat_q;

  assign in_range = {1'b0, acc_addr} < DEPTH_W;
  assign mem_idx  = acc_addr[IW-1:0];

  // The edge that moves the FSM into RESP is the one that touches memory.
  assign go_resp = ((state_q == S_IDLE) && req && (WAIT_STATES == 0)) ||
                   ((state_q == S_WAIT) && i_cyc && (cnt_q == 4'd1));

  assign mem_wr    = go_resp & acc_we & in_range;
  assign mem_rd    = go_resp & ~acc_we & in_range;
  assign resp_mask = mem_rd ? acc_stb : '0;

  // Memory array: byte-lane synchronous write and registered read, no reset.
  always_ff @(posedge i_clk) begin
    if (mem_wr) begin
      for (int k = 0; k < SW; k++) begin
        if (acc_stb[k]) mem[mem_idx][8*k +: 8] <= acc_dat[8*k +: 8];
      end
    end
    if (mem_rd) rd_q <= mem[mem_idx];
  end

  // Access sequencer: accept, count wait states, handle abort, pulse response.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      stb_q     <= '0;
      dat_q     <= '0;
      rd_mask_q <= '0;
      o_ack     <= 1'b0;
      o_err     <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          o_ack     <= 1'b0;
          o_err     <= 1'b0;
          rd_mask_q <= '0;
          if (req) begin
            addr_q <= i_addr;
            we_q   <= i_we;
            stb_q  <= i_stb;
            dat_q  <= i_dat;
            cnt_q  <= WS4;
            o_busy <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_q   <= S_RESP;
              o_ack     <= in_range;
              o_err     <= ~in_range;
              rd_mask_q <= resp_mask;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!i_cyc) begin
            // Master abandoned the cycle: drop it silently.
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            o_busy  <= 1'b0;
          end else if (cnt_q == 4'd1) begin
            state_q   <= S_RESP;
            cnt_q     <= 4'd0;
            o_ack     <= in_range;
            o_err     <= ~in_range;
            rd_mask_q <= resp_mask;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          // The response always completes; i_cyc is ignored here.
          state_q   <= S_IDLE;
          o_ack     <= 1'b0;
          o_err     <= 1'b0;
          o_busy    <= 1'b0;
          rd_mask_q <= '0;
        end
        default: begin
          state_q   <= S_IDLE;
          o_ack     <= 1'b0;
          o_err     <= 1'b0;
          o_busy    <= 1'b0;
          rd_mask_q <= '0;
        end
      endcase
    end
  end

  // Read data is the registered RAM word gated per lane by a registered mask,
  // so it is zero outside a read ack and clears asynchronously on reset.
  always_comb begin
    o_dat = '0;
    for (int k = 0; k < SW; k++) begin
      o_dat[8*k +: 8] = rd_mask_q[k] ? rd_q[8*k +: 8] : 8'h00;
    end
  end

endmodule

// File: tb/tb_blkmem_wb.sv
module tb_blkmem_wb;

  localparam int NU = 4;
  localparam int WS_T [NU] = '{0, 3, 2, 4};

  logic          clk;
  logic [NU-1:0] rst_n;
  logic [NU-1:0] we;
  logic [NU-1:0] cyc;
  logic [NU-1:0] ack;
  logic [NU-1:0] err;
  logic [NU-1:0] busy;
  logic [15:0]   wdat [NU];
  logic [15:0]   rdat [NU];
  logic [10:0]   addr [NU];
  logic [1:0]    stb  [NU];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    blkmem_wb #(
      .DW(16), .AW(11), .DEPTH(1024), .WAIT_STATES(WS_T[g])
    ) u_dut (
      .i_clk    (clk),
      .i_reset_n(rst_n[g]),
      .i_dat    (wdat[g]),
      .o_dat    (rdat[g]),
      .i_addr   (addr[g]),
      .i_we     (we[g]),
      .i_cyc    (cyc[g]),
      .i_stb    (stb[g]),
      .o_ack    (ack[g]),
      .o_err    (err[g]),
      .o_busy   (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input int u, input string tag);
    check({tag, "_ack"}, ack[u], 0);
    check({tag, "_err"}, err[u], 0);
    check({tag, "_busy"}, busy[u], 0);
    check({tag, "_dat"}, rdat[u], 0);
  endtask

  // One complete access; scramble changes the bus fields after acceptance.
  task automatic access(input int u, input bit w, input logic [10:0] a, input logic [15:0] d,
                        input logic [1:0] s, input bit scramble, input bit exp_err,
                        input logic [15:0] exp_rd);
    int n;
    bit done;
    we[u] = w; addr[u] = a; wdat[u] = d; stb[u] = s; cyc[u] = 1'b1;
    n = 0;
    done = 0;
    while (!done && n < 40) begin
      tick();
      n++;
      if (scramble && n == 1) begin
        we[u] = ~w; addr[u] = a ^ 11'h001; wdat[u] = ~d; stb[u] = s ^ 2'b01;
      end
      if (ack[u] || err[u]) done = 1;
      else begin
        check("wait_busy", busy[u], 1);
        check("wait_dat", rdat[u], 0);
      end
    end
    check("latency", n, WS_T[u] + 1);
    check("ack", ack[u], !exp_err);
    check("err", err[u], exp_err);
    check("busy_resp", busy[u], 1);
    check("rd_dat", rdat[u], (w || exp_err) ? 16'h0 : exp_rd);
    cyc[u] = 1'b0; stb[u] = 2'b00;
    tick();
    idle_check(u, "post");
  endtask

  initial begin
    logic [9:0] ackpat;
    logic [9:0] busypat;
    rst_n = '0; we = '0; cyc = '0;
    for (int i = 0; i < NU; i++) begin
      wdat[i] = '0; addr[i] = '0; stb[i] = '0;
    end

    // Reset held for three cycles, then idle.
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int u = 0; u < NU; u++) idle_check(u, "rst");
    end
    rst_n = '1;
    for (int c = 0; c < 2; c++) begin
      tick();
      for (int u = 0; u < NU; u++) idle_check(u, "idle");
    end

    // No wait states: full word and byte lanes.
    access(0, 1, 11'h010, 16'hBEEF, 2'b11, 0, 0, 16'h0);
    access(0, 0, 11'h010, 16'h0,    2'b11, 0, 0, 16'hBEEF);
    access(0, 1, 11'h005, 16'h1234, 2'b11, 0, 0, 16'h0);
    access(0, 1, 11'h005, 16'hAB00, 2'b10, 0, 0, 16'h0);
    access(0, 0, 11'h005, 16'h0,    2'b11, 0, 0, 16'hAB34);
    access(0, 0, 11'h005, 16'h0,    2'b01, 0, 0, 16'h0034);
    access(0, 0, 11'h005, 16'h0,    2'b10, 0, 0, 16'hAB00);

    // Three wait states: latency, fields ignored after acceptance, spacing.
    access(1, 1, 11'h00A, 16'h0A0A, 2'b11, 0, 0, 16'h0);
    access(1, 1, 11'h00B, 16'h4242, 2'b11, 1, 0, 16'h0);
    access(1, 0, 11'h00B, 16'h0,    2'b11, 0, 0, 16'h4242);
    access(1, 0, 11'h00A, 16'h0,    2'b11, 0, 0, 16'h0A0A);
    access(1, 1, 11'h009, 16'h7777, 2'b11, 0, 0, 16'h0);
    we[1] = 1'b0; addr[1] = 11'h009; stb[1] = 2'b11; cyc[1] = 1'b1;
    ackpat = '0;
    busypat = '0;
    for (int t = 0; t < 10; t++) begin
      tick();
      ackpat[t]  = ack[1];
      busypat[t] = busy[1];
      if (ack[1]) check("b2b_dat", rdat[1], 16'h7777);
    end
    check("b2b_ack", ackpat, 10'h108);
    check("b2b_busy", busypat, 10'h1EF);
    cyc[1] = 1'b0; stb[1] = 2'b00;
    tick();
    tick();
    idle_check(1, "b2b_end");

    // Two wait states: abort, then out-of-range errors and the top word.
    access(2, 1, 11'd7, 16'h1111, 2'b11, 0, 0, 16'h0);
    we[2] = 1'b1; addr[2] = 11'd7; wdat[2] = 16'h5555; stb[2] = 2'b11; cyc[2] = 1'b1;
    tick();
    check("abort_busy", busy[2], 1);
    cyc[2] = 1'b0; stb[2] = 2'b00;
    tick();
    idle_check(2, "abort");
    for (int c = 0; c < 4; c++) begin
      tick();
      idle_check(2, "abort_q");
    end
    access(2, 0, 11'd7,    16'h0,    2'b11, 0, 0, 16'h1111);
    access(2, 1, 11'd0,    16'h2222, 2'b11, 0, 0, 16'h0);
    access(2, 1, 11'd1024, 16'h9999, 2'b11, 0, 1, 16'h0);
    access(2, 0, 11'd1024, 16'h0,    2'b11, 0, 1, 16'h0);
    access(2, 0, 11'd0,    16'h0,    2'b11, 0, 0, 16'h2222);
    access(2, 1, 11'd1023, 16'h3C3C, 2'b11, 0, 0, 16'h0);
    access(2, 0, 11'd1023, 16'h0,    2'b11, 0, 0, 16'h3C3C);

    // Four wait states: reset two cycles into a write drops it.
    access(3, 1, 11'd3, 16'h0F0F, 2'b11, 0, 0, 16'h0);
    we[3] = 1'b1; addr[3] = 11'd3; wdat[3] = 16'hCAFE; stb[3] = 2'b11; cyc[3] = 1'b1;
    tick();
    tick();
    check("mid_busy", busy[3], 1);
    #2 rst_n[3] = 1'b0;
    #1 idle_check(3, "async_rst");
    cyc[3] = 1'b0; stb[3] = 2'b00;
    tick();
    tick();
    rst_n[3] = 1'b1;
    tick();
    idle_check(3, "after_rst");
    access(3, 0, 11'd3, 16'h0, 2'b11, 0, 0, 16'h0F0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
